// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC, 16-line direct-mapped one-word I-cache,
// miss handling via word reads, and one push per cycle into the instruction queue.
//
// state    | meaning
// FETCH    | look up pc; push on hit, issue read on miss, redirect on roll_back
// WAIT_MEM | read outstanding at mem_addr; fill the line when mem_done arrives
module fetch_controller #(
    parameter int          ICACHE_LINES = 16,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] roll_back_pc,
    input  logic        isq_almost_full,
    output logic        instruction_ready,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 32 - 2 - IDX_W;

    typedef enum logic {FETCH, WAIT_MEM} state_t;

    state_t state, state_next;

    logic [31:0] pc, pc_next;
    logic        ready_next;
    logic [31:0] instr_next, pc_out_next;
    logic        req_next;
    logic [31:0] addr_next;

    logic [ICACHE_LINES-1:0] valid;
    logic [31:0]             line_data [ICACHE_LINES];
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];

    logic [IDX_W-1:0] idx, fill_idx;
    logic             hit, fill;

    assign idx      = pc[IDX_W+1:2];
    assign fill_idx = mem_addr[IDX_W+1:2];
    assign hit      = valid[idx] && (line_tag[idx] == pc[31:IDX_W+2]);
    assign fill     = rdy_in && (state == WAIT_MEM) && mem_done;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rdy_in) begin
            case (state)
                FETCH:    if (!roll_back && !hit) state_next = WAIT_MEM;
                WAIT_MEM: if (mem_done) state_next = FETCH;
                default:  state_next = FETCH;
            endcase
        end
    end

    always_comb begin
        pc_next     = pc;
        ready_next  = instruction_ready;
        instr_next  = instruction_out;
        pc_out_next = pc_out;
        req_next    = mem_req;
        addr_next   = mem_addr;
        if (rdy_in) begin
            case (state)
                FETCH: begin
                    ready_next = 1'b0;
                    if (roll_back) begin
                        pc_next = roll_back_pc;
                    end else if (hit) begin
                        if (!isq_almost_full) begin
                            ready_next  = 1'b1;
                            instr_next  = line_data[idx];
                            pc_out_next = pc;
                            pc_next     = pc + 32'd4;
                        end
                    end else begin
                        req_next  = 1'b1;
                        addr_next = {pc[31:2], 2'b00};
                    end
                end
                WAIT_MEM: begin
                    ready_next = 1'b0;
                    // the outstanding read is never aborted; only the pc moves
                    if (roll_back) pc_next = roll_back_pc;
                    if (mem_done)  req_next = 1'b0;
                end
                default: ready_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc                <= RESET_PC;
            instruction_ready <= 1'b0;
            instruction_out   <= 32'h0;
            pc_out            <= 32'h0;
            mem_req           <= 1'b0;
            mem_addr          <= 32'h0;
        end else begin
            pc                <= pc_next;
            instruction_ready <= ready_next;
            instruction_out   <= instr_next;
            pc_out            <= pc_out_next;
            mem_req           <= req_next;
            mem_addr          <= addr_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)    valid           <= '0;
        else if (fill) valid[fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            line_data[fill_idx] <= mem_data;
            line_tag[fill_idx]  <= mem_addr[31:IDX_W+2];
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller: a transaction-level fetch model with an
// address-keyed cache map is stepped alongside the DUT and compared every cycle.
module tb_fetch_controller;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        roll_back = 1'b0;
    logic [31:0] roll_back_pc = 32'h0;
    logic        isq_almost_full = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        instruction_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        mem_req;
    logic [31:0] mem_addr;

    fetch_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .roll_back(roll_back), .roll_back_pc(roll_back_pc),
        .isq_almost_full(isq_almost_full),
        .instruction_ready(instruction_ready), .instruction_out(instruction_out),
        .pc_out(pc_out), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int pushes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // read-only code image: every word is a fixed function of its address
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    // reference model: cache as a map line -> cached word address
    logic [31:0] line_addr [int];
    logic [31:0] m_pc, m_iout, m_pcout, m_addr;
    bit          m_ir, m_req, m_wait;
    bit          mem_pending;
    int          mem_cnt;

    task automatic model_reset();
        line_addr.delete();
        m_pc = 32'h0; m_iout = 32'h0; m_pcout = 32'h0; m_addr = 32'h0;
        m_ir = 0; m_req = 0; m_wait = 0;
        mem_pending = 0; mem_cnt = 0;
    endtask

    // Called at a negedge: compare, drive the next cycle's inputs, advance the model.
    task automatic step(input int pct_rdy_low, input int pct_rb, input int pct_af);
        bit hit;
        check("instruction_ready", 32'(instruction_ready), 32'(m_ir));
        check("instruction_out", instruction_out, m_iout);
        check("pc_out", pc_out, m_pcout);
        check("mem_req", 32'(mem_req), 32'(m_req));
        check("mem_addr", mem_addr, m_addr);
        if (instruction_ready && rdy_in) pushes++;

        rdy_in          = ($urandom_range(0, 99) >= pct_rdy_low);
        roll_back       = ($urandom_range(0, 99) < pct_rb);
        roll_back_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                                       : ($urandom_range(0, 63) << 2);
        isq_almost_full = ($urandom_range(0, 99) < pct_af);
        mem_done        = 1'b0;
        mem_data        = $urandom;
        if (mem_req && !mem_pending) begin
            mem_pending = 1;
            mem_cnt     = $urandom_range(0, 3);
        end
        if (rdy_in && mem_pending) begin
            if (mem_cnt == 0) begin
                mem_done    = 1'b1;
                mem_data    = memfn(mem_addr);
                mem_pending = 0;
            end else begin
                mem_cnt--;
            end
        end

        if (rdy_in) begin
            if (!m_wait) begin
                hit = line_addr.exists(line_of(m_pc)) && (line_addr[line_of(m_pc)] == m_pc);
                m_ir = 0;
                if (roll_back) begin
                    m_pc = roll_back_pc;
                end else if (hit) begin
                    if (!isq_almost_full) begin
                        m_ir = 1; m_iout = memfn(m_pc); m_pcout = m_pc; m_pc = m_pc + 32'd4;
                    end
                end else begin
                    m_req = 1; m_addr = m_pc; m_wait = 1;
                end
            end else begin
                m_ir = 0;
                if (roll_back) m_pc = roll_back_pc;
                if (mem_done) begin
                    line_addr[line_of(m_addr)] = m_addr;
                    m_req = 0; m_wait = 0;
                end
            end
        end
        @(negedge clk_in);
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", 32'(instruction_ready), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr", instruction_out, 32'h0);
        rst_in = 1'b0;

        repeat (60) step(0, 0, 0);
        repeat (1500) step(10, 5, 20);
        repeat (200) step(0, 2, 0);

        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mem_req === 1'b1) found = 1;
            else step(0, 0, 0);
        end
        check("wait_mem_req_seen", 32'(found), 32'h1);
        #2 rst_in = 1'b1;
        mem_done = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'h0);
        check("async_rst_mem_addr", mem_addr, 32'h0);
        check("async_rst_ready", 32'(instruction_ready), 32'h0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;

        repeat (400) step(10, 5, 20);
        check("pushes_seen", 32'(pushes > 100), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
